// File: rtl/tile_render_pkg.sv
// tile_render_pkg: shared widths, pipeline depth and byte-lane helper for the tile renderer
package tile_render_pkg;
  localparam int PIX_X_W      = 11;
  localparam int PIX_Y_W      = 10;
  localparam int COLOR_IDX_W  = 8;
  localparam int PIPE_LATENCY = 4;
  function automatic logic [COLOR_IDX_W-1:0] byte_lane_select(input logic [31:0] word, input logic [1:0] lane);
    return word[8*lane +: 8];
  endfunction
endpackage

// File: rtl/tile_layer_fetch.sv
// tile_layer_fetch: one layer's scroll wrap, tile lookup and two-stage RAM fetch down to a colour index
//   clk_i/rst_ni           clock, async active-low reset
//   pix_x_i/pix_y_i        screen coordinate (S0)
//   scroll_x_i/scroll_y_i  committed scroll for this layer
//   active_i/en_i          pixel visible / layer enabled
//   idx_addr_o/idx_rdata_i tile-index RAM word address (S0) and data (S1)
//   img_addr_o/img_rdata_i tile-image RAM word address (S1) and data (S2)
//   color_idx_o/valid_o    colour index and active&enabled flag (S2)
module tile_layer_fetch
  import tile_render_pkg::*;
#(
  parameter int TILES_PER_LINE = 100,
  parameter int TILE_ROWS      = 60,
  parameter int TILE_LOG2      = 3,
  parameter int MEM_ADDR_W     = 30
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [PIX_X_W-1:0]     pix_x_i,
  input  logic [PIX_Y_W-1:0]     pix_y_i,
  input  logic [PIX_X_W-1:0]     scroll_x_i,
  input  logic [PIX_Y_W-1:0]     scroll_y_i,
  input  logic                   active_i,
  input  logic                   en_i,
  output logic [MEM_ADDR_W-1:0]  idx_addr_o,
  input  logic [31:0]            idx_rdata_i,
  output logic [MEM_ADDR_W-1:0]  img_addr_o,
  input  logic [31:0]            img_rdata_i,
  output logic [COLOR_IDX_W-1:0] color_idx_o,
  output logic                   valid_o
);
  localparam logic [PIX_X_W:0] MAP_W = (PIX_X_W+1)'(TILES_PER_LINE << TILE_LOG2);
  localparam logic [PIX_Y_W:0] MAP_H = (PIX_Y_W+1)'(TILE_ROWS << TILE_LOG2);
  localparam int OFF_W = 2 * TILE_LOG2;
  logic [PIX_X_W:0] ex_sum, ex;
  logic [PIX_Y_W:0] ey_sum, ey;
  logic [31:0] tile_n;
  logic [COLOR_IDX_W+OFF_W-1:0] img_byte;
  logic [1:0] lane0_q, lane1_q;
  logic [OFF_W-1:0] off_q;
  logic v1_q, v2_q;
  // both operands are below the map size, so one conditional subtract wraps
  assign ex_sum = {1'b0, pix_x_i} + {1'b0, scroll_x_i};
  assign ey_sum = {1'b0, pix_y_i} + {1'b0, scroll_y_i};
  assign ex = (ex_sum >= MAP_W) ? ex_sum - MAP_W : ex_sum;
  assign ey = (ey_sum >= MAP_H) ? ey_sum - MAP_H : ey_sum;
  assign tile_n = 32'(ey >> TILE_LOG2) * 32'(TILES_PER_LINE) + 32'(ex >> TILE_LOG2);
  assign idx_addr_o = MEM_ADDR_W'(tile_n >> 2);
  // tile images are byte-addressed as {tile_id, row, col}
  assign img_byte = {byte_lane_select(idx_rdata_i, lane0_q), off_q};
  assign img_addr_o = MEM_ADDR_W'(img_byte >> 2);
  assign color_idx_o = byte_lane_select(img_rdata_i, lane1_q);
  assign valid_o = v2_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane0_q <= '0;
      off_q   <= '0;
      v1_q    <= 1'b0;
      lane1_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      lane0_q <= tile_n[1:0];
      off_q   <= {ey[TILE_LOG2-1:0], ex[TILE_LOG2-1:0]};
      v1_q    <= active_i & en_i;
      lane1_q <= img_byte[1:0];
      v2_q    <= v1_q;
    end
  end
endmodule

// File: rtl/tile_layer_renderer.sv
// tile_layer_renderer: multi-layer tile-map pixel pipeline with shadowed scroll and priority compositing
//   display_clock/reset         clock, async active-low reset
//   i_new_frame                 commits pending scroll values
//   i_active/i_pix_x/i_pix_y    coordinate stream, i_layer_en per-layer enables
//   i_scroll_*                  scroll write port into the pending registers
//   o_tiles_idx_addr/i_tiles_idx_readdata  per-layer tile-index RAMs
//   o_tiles_addr/i_tiles_readdata          per-layer tile-image RAMs
//   o_colormap_addr/i_colormap_readdata    shared colormap RAM
//   o_pixel_data/o_pixel_valid  composed colour, four edges after the coordinate
module tile_layer_renderer
  import tile_render_pkg::*;
#(
  parameter int          NUM_LAYERS      = 2,
  parameter int          TILES_PER_LINE  = 100,
  parameter int          TILE_ROWS       = 60,
  parameter int          TILE_LOG2       = 3,
  parameter int          MEM_ADDR_W      = 30,
  parameter logic [7:0]  TRANSPARENT_IDX = 8'h00,
  parameter logic [31:0] BLANK_COLOR     = 32'h0,
  localparam int         LAYER_W         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                             display_clock,
  input  logic                             reset,
  input  logic                             i_new_frame,
  input  logic                             i_active,
  input  logic [PIX_X_W-1:0]               i_pix_x,
  input  logic [PIX_Y_W-1:0]               i_pix_y,
  input  logic [NUM_LAYERS-1:0]            i_layer_en,
  input  logic                             i_scroll_we,
  input  logic [LAYER_W-1:0]               i_scroll_layer,
  input  logic [PIX_X_W-1:0]               i_scroll_x,
  input  logic [PIX_Y_W-1:0]               i_scroll_y,
  output logic [NUM_LAYERS*MEM_ADDR_W-1:0] o_tiles_idx_addr,
  input  logic [NUM_LAYERS*32-1:0]         i_tiles_idx_readdata,
  output logic [NUM_LAYERS*MEM_ADDR_W-1:0] o_tiles_addr,
  input  logic [NUM_LAYERS*32-1:0]         i_tiles_readdata,
  output logic [COLOR_IDX_W-1:0]           o_colormap_addr,
  input  logic [31:0]                      i_colormap_readdata,
  output logic [31:0]                      o_pixel_data,
  output logic                             o_pixel_valid
);
  localparam logic [PIX_X_W:0] MAP_W = (PIX_X_W+1)'(TILES_PER_LINE << TILE_LOG2);
  localparam logic [PIX_Y_W:0] MAP_H = (PIX_Y_W+1)'(TILE_ROWS << TILE_LOG2);
  logic [NUM_LAYERS-1:0][PIX_X_W-1:0] pend_x_q, pend_x_d, act_x_q;
  logic [NUM_LAYERS-1:0][PIX_Y_W-1:0] pend_y_q, pend_y_d, act_y_q;
  logic [NUM_LAYERS-1:0][COLOR_IDX_W-1:0] color_idx;
  logic [NUM_LAYERS-1:0] layer_vld;
  logic [COLOR_IDX_W-1:0] win_idx;
  logic [PIPE_LATENCY-2:0] act_q;
  logic write_ok;
  assign write_ok = i_scroll_we && ({1'b0, i_scroll_x} < MAP_W) && ({1'b0, i_scroll_y} < MAP_H);
  // layer numbers beyond NUM_LAYERS match no entry, so such writes fall through
  always_comb begin
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      pend_x_d[l] = (write_ok && i_scroll_layer == LAYER_W'(l)) ? i_scroll_x : pend_x_q[l];
      pend_y_d[l] = (write_ok && i_scroll_layer == LAYER_W'(l)) ? i_scroll_y : pend_y_q[l];
    end
  end
  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    tile_layer_fetch #(
      .TILES_PER_LINE(TILES_PER_LINE),
      .TILE_ROWS     (TILE_ROWS),
      .TILE_LOG2     (TILE_LOG2),
      .MEM_ADDR_W    (MEM_ADDR_W)
    ) u_fetch (
      .clk_i      (display_clock),
      .rst_ni     (reset),
      .pix_x_i    (i_pix_x),
      .pix_y_i    (i_pix_y),
      .scroll_x_i (act_x_q[g]),
      .scroll_y_i (act_y_q[g]),
      .active_i   (i_active),
      .en_i       (i_layer_en[g]),
      .idx_addr_o (o_tiles_idx_addr[g*MEM_ADDR_W +: MEM_ADDR_W]),
      .idx_rdata_i(i_tiles_idx_readdata[g*32 +: 32]),
      .img_addr_o (o_tiles_addr[g*MEM_ADDR_W +: MEM_ADDR_W]),
      .img_rdata_i(i_tiles_readdata[g*32 +: 32]),
      .color_idx_o(color_idx[g]),
      .valid_o    (layer_vld[g])
    );
  end
  // layer 0 is opaque; higher layers override only with a non-transparent index
  always_comb begin
    win_idx = layer_vld[0] ? color_idx[0] : '0;
    for (int l = 1; l < NUM_LAYERS; l++)
      win_idx = (layer_vld[l] && color_idx[l] != TRANSPARENT_IDX) ? color_idx[l] : win_idx;
  end
  assign o_colormap_addr = win_idx;
  always_ff @(posedge display_clock or negedge reset) begin
    if (!reset) begin
      pend_x_q      <= '0;
      pend_y_q      <= '0;
      act_x_q       <= '0;
      act_y_q       <= '0;
      act_q         <= '0;
      o_pixel_data  <= '0;
      o_pixel_valid <= 1'b0;
    end else begin
      pend_x_q      <= pend_x_d;
      pend_y_q      <= pend_y_d;
      act_x_q       <= i_new_frame ? pend_x_d : act_x_q;
      act_y_q       <= i_new_frame ? pend_y_d : act_y_q;
      act_q         <= {act_q[PIPE_LATENCY-3:0], i_active};
      o_pixel_data  <= act_q[PIPE_LATENCY-2] ? i_colormap_readdata : BLANK_COLOR;
      o_pixel_valid <= act_q[PIPE_LATENCY-2];
    end
  end
endmodule

// File: tb/tb_tile_layer_renderer.sv
// tb_tile_layer_renderer: directed and randomized checks of the tile renderer against a behavioural model
module tb_tile_layer_renderer;
  localparam int NL = 2;
  localparam int AW = 30;
  logic display_clock = 1'b0;
  logic reset = 1'b0;
  logic nf = 1'b0, active = 1'b0, swe = 1'b0;
  logic [10:0] x = '0, sx = '0;
  logic [9:0] y = '0, sy = '0;
  logic [NL-1:0] en = '0;
  logic [0:0] slayer = '0;
  logic [NL*AW-1:0] idx_addr, img_addr;
  logic [NL*32-1:0] idx_rd, img_rd;
  logic [7:0] cmap_addr;
  logic [31:0] cmap_rd, pix;
  logic pv;
  logic [31:0] idx_mem[NL][2048];
  logic [31:0] img_mem[NL][4096];
  logic [31:0] cmap[256];
  int pend_x[NL], pend_y[NL], cur_x[NL], cur_y[NL];
  logic [32:0] expq[$];
  int total = 0, bad = 0;

  always #5 display_clock = ~display_clock;

  tile_layer_renderer dut (
    .display_clock(display_clock), .reset(reset), .i_new_frame(nf), .i_active(active),
    .i_pix_x(x), .i_pix_y(y), .i_layer_en(en), .i_scroll_we(swe), .i_scroll_layer(slayer),
    .i_scroll_x(sx), .i_scroll_y(sy), .o_tiles_idx_addr(idx_addr), .i_tiles_idx_readdata(idx_rd),
    .o_tiles_addr(img_addr), .i_tiles_readdata(img_rd), .o_colormap_addr(cmap_addr),
    .i_colormap_readdata(cmap_rd), .o_pixel_data(pix), .o_pixel_valid(pv)
  );

  always @(posedge display_clock) begin
    for (int l = 0; l < NL; l++) begin
      idx_rd[l*32 +: 32] <= idx_mem[l][idx_addr[l*AW +: 11]];
      img_rd[l*32 +: 32] <= img_mem[l][img_addr[l*AW +: 12]];
    end
    cmap_rd <= cmap[cmap_addr];
  end

  function automatic logic [32:0] model(int px, int py, logic a, logic [NL-1:0] e);
    int ex, ey, n, tid, b, c, idx;
    if (!a) return {1'b0, 32'h0};
    idx = 0;
    for (int l = 0; l < NL; l++) if (e[l]) begin
      ex = (px + cur_x[l]) % 800;
      ey = (py + cur_y[l]) % 480;
      n = (ey / 8) * 100 + ex / 8;
      tid = int'((idx_mem[l][n/4] >> (8 * (n % 4))) & 32'hFF);
      b = tid * 64 + (ey % 8) * 8 + ex % 8;
      c = int'((img_mem[l][b/4] >> (8 * (b % 4))) & 32'hFF);
      if (l == 0 || c != 0) idx = c;
    end
    return {1'b1, cmap[idx]};
  endfunction

  always @(posedge display_clock) begin
    if (!reset) begin
      expq.delete();
      for (int l = 0; l < NL; l++) begin pend_x[l] = 0; pend_y[l] = 0; cur_x[l] = 0; cur_y[l] = 0; end
    end else begin
      expq.push_back(model(int'(x), int'(y), active, en));
      if (swe && sx < 800 && sy < 480 && int'(slayer) < NL) begin
        pend_x[slayer] = int'(sx);
        pend_y[slayer] = int'(sy);
      end
      if (nf) for (int l = 0; l < NL; l++) begin cur_x[l] = pend_x[l]; cur_y[l] = pend_y[l]; end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, want);
    end
  endtask

  always @(negedge display_clock) begin
    if (reset && expq.size() == 4) begin
      chk("pixel", 64'({pv, pix}), 64'(expq[0]));
      void'(expq.pop_front());
    end
  end

  task automatic drv(input int px, input int py, input logic a, input logic [NL-1:0] e);
    x = 11'(px); y = 10'(py); active = a; en = e;
  endtask

  task automatic wr(input int l, input int vx, input int vy, input logic f);
    drv(0, 0, 1'b0, '0);
    swe = 1'b1; slayer = 1'(l); sx = 11'(vx); sy = 10'(vy); nf = f;
    @(negedge display_clock);
    swe = 1'b0; nf = 1'b0;
  endtask

  task automatic one(input int px, input int py, input logic a, input logic [NL-1:0] e,
                     input string nm, input logic [32:0] want);
    drv(px, py, a, e);
    @(negedge display_clock);
    drv(0, 0, 1'b0, '0);
    repeat (3) @(negedge display_clock);
    chk(nm, 64'({pv, pix}), 64'(want));
  endtask

  initial begin
    for (int l = 0; l < NL; l++) begin
      for (int i = 0; i < 2048; i++) idx_mem[l][i] = $urandom;
      for (int i = 0; i < 4096; i++) img_mem[l][i] = $urandom;
    end
    for (int i = 0; i < 256; i++) cmap[i] = $urandom;
    repeat (3) @(negedge display_clock);
    chk("rst_valid", 64'(pv), 64'(0));
    chk("rst_data", 64'(pix), 64'(0));
    reset = 1'b1;
    @(negedge display_clock);
    // single layer, no scroll: x=17 y=9 -> tile 102, word 25 lane 2, image byte 457
    idx_mem[0][25] = 32'h0007_0000;
    img_mem[0][114] = 32'hAABB_2ACC;
    cmap[8'h2A] = 32'h00FF_8800;
    drv(17, 9, 1'b1, 2'b01);
    #1 chk("idx_addr", 64'(idx_addr[AW-1:0]), 64'd25);
    @(negedge display_clock);
    drv(0, 0, 1'b0, '0);
    chk("img_addr", 64'(img_addr[AW-1:0]), 64'd114);
    @(negedge display_clock);
    chk("cmap_addr", 64'(cmap_addr), 64'h2A);
    repeat (2) @(negedge display_clock);
    chk("pix1", 64'({pv, pix}), 64'({1'b1, 32'h00FF_8800}));
    // horizontal wrap: 5+797 wraps to 2 -> tile 0, image byte offset 2
    idx_mem[0][0] = 32'h1234_5605;
    wr(0, 797, 0, 1'b1);
    drv(5, 0, 1'b1, 2'b01);
    #1 chk("wrap_idx", 64'(idx_addr[AW-1:0]), 64'd0);
    @(negedge display_clock);
    drv(0, 0, 1'b0, '0);
    chk("wrap_img", 64'(img_addr[AW-1:0]), 64'd80);
    repeat (4) @(negedge display_clock);
    // shadowing: mid-frame write invisible, write with new_frame used at once, out-of-map dropped
    wr(0, 8, 0, 1'b0);
    drv(0, 0, 1'b1, 2'b01);
    #1 chk("shadow_hold", 64'(idx_addr[AW-1:0]), 64'd24);
    @(negedge display_clock);
    wr(0, 40, 0, 1'b1);
    drv(0, 0, 1'b1, 2'b01);
    #1 chk("shadow_commit", 64'(idx_addr[AW-1:0]), 64'd1);
    @(negedge display_clock);
    wr(0, 800, 0, 1'b1);
    drv(0, 0, 1'b1, 2'b01);
    #1 chk("scroll_drop", 64'(idx_addr[AW-1:0]), 64'd1);
    @(negedge display_clock);
    drv(0, 0, 1'b0, '0);
    repeat (5) @(negedge display_clock);
    // compositing at (0,0): layer0 (scroll 40) -> tile 9 -> 0x77, layer1 -> tile 3 -> word 48
    idx_mem[0][1] = 32'h0000_0900;
    img_mem[0][144] = 32'h0000_0077;
    idx_mem[1][0] = 32'h0000_0003;
    img_mem[1][48] = 32'h0000_0000;
    cmap[8'h77] = 32'hCAFE_0077;
    cmap[8'h05] = 32'h0505_0505;
    cmap[8'h00] = 32'h0BAD_F00D;
    one(0, 0, 1'b1, 2'b11, "comp_transparent", {1'b1, 32'hCAFE_0077});
    img_mem[1][48] = 32'h0000_0005;
    one(0, 0, 1'b1, 2'b11, "comp_layer1", {1'b1, 32'h0505_0505});
    one(0, 0, 1'b1, 2'b01, "comp_layer1_off", {1'b1, 32'hCAFE_0077});
    one(0, 0, 1'b1, 2'b00, "comp_none", {1'b1, 32'h0BAD_F00D});
    one(0, 0, 1'b0, 2'b11, "blank", {1'b0, 32'h0});
    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drv(int'($urandom_range(799)), int'($urandom_range(479)), ($urandom % 8) != 0, NL'($urandom));
      swe = ($urandom % 16) == 0;
      slayer = 1'($urandom);
      sx = ($urandom % 8 == 0) ? 11'(800 + $urandom_range(1247)) : 11'($urandom_range(799));
      sy = ($urandom % 8 == 0) ? 10'(480 + $urandom_range(543)) : 10'($urandom_range(479));
      nf = ($urandom % 50) == 0;
      @(negedge display_clock);
    end
    swe = 1'b0; nf = 1'b0;
    // reset with pixels in flight
    for (int i = 0; i < 6; i++) begin
      drv(int'($urandom_range(799)), int'($urandom_range(479)), 1'b1, 2'b11);
      @(negedge display_clock);
    end
    chk("pre_reset_valid", 64'(pv), 64'(1));
    #2 reset = 1'b0;
    #1 chk("rst_async_valid", 64'(pv), 64'(0));
    chk("rst_async_data", 64'(pix), 64'(0));
    drv(0, 0, 1'b0, '0);
    repeat (2) @(negedge display_clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge display_clock);
      chk("rst_no_stale", 64'(pv), 64'(0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tile_layer_renderer.md
Name: tile_layer_renderer

Overview:
Multi-layer tile-map pixel pipeline for the MTL display path, running in the display clock domain. For each pixel coordinate it produces a 32-bit colour. Every layer has its own scroll offset, tile-index RAM and tile-image RAM. Layers are composited by priority with a transparent index, through one shared colormap RAM. It sits between the MTL timing generator (coordinates, active, new-frame) and the display RAMs, and drives o_pixel_data into the LCD path.

Parameters:
NUM_LAYERS, 2, number of tile layers; layer NUM_LAYERS-1 has highest priority
TILES_PER_LINE, 100, map width in tiles
TILE_ROWS, 60, map height in tiles
TILE_LOG2, 3, log2 of tile edge in pixels (8x8 tiles)
MEM_ADDR_W, 30, word-address width of the tile-index and tile-image RAMs
TRANSPARENT_IDX, 8'h00, colour index that is see-through on layers 1..NUM_LAYERS-1
BLANK_COLOR, 32'h0, pixel output outside the active area

Ports:
display_clock  in  1  display clock (33 MHz)
reset  in  1  asynchronous, active-low reset
i_new_frame  in  1  one-cycle pulse at frame start
i_active  in  1  coordinate on i_pix_x/i_pix_y is a visible pixel
i_pix_x  in  11  pixel column
i_pix_y  in  10  pixel row
i_layer_en  in  NUM_LAYERS  per-layer enable, sampled with the coordinate
i_scroll_we  in  1  scroll register write strobe
i_scroll_layer  in  $clog2(NUM_LAYERS) (min 1)  target layer
i_scroll_x  in  11  horizontal scroll value
i_scroll_y  in  10  vertical scroll value
o_tiles_idx_addr  out  NUM_LAYERS*MEM_ADDR_W  per-layer tile-index word address
i_tiles_idx_readdata  in  NUM_LAYERS*32  per-layer tile-index data, 1-cycle synchronous RAM
o_tiles_addr  out  NUM_LAYERS*MEM_ADDR_W  per-layer tile-image word address
i_tiles_readdata  in  NUM_LAYERS*32  per-layer tile-image data, 1-cycle synchronous RAM
o_colormap_addr  out  8  shared colormap address
i_colormap_readdata  in  32  colormap data, 1-cycle synchronous RAM
o_pixel_data  out  32  composed pixel colour
o_pixel_valid  out  1  o_pixel_data corresponds to an active pixel

Behaviour:
- Reset (reset=0, async): o_pixel_data=0, o_pixel_valid=0, all pipeline valid bits 0, pending and active scroll registers 0. Address outputs are combinational from pipeline state and hold no reset requirement.
- Map size: MAP_W = TILES_PER_LINE<<TILE_LOG2 and MAP_H = TILE_ROWS<<TILE_LOG2 (800x480 by default).
- Scroll writes: on i_scroll_we, if i_scroll_x<MAP_W and i_scroll_y<MAP_H, pending[layer] takes both values. Otherwise the write is dropped entirely and pending is unchanged. A write to layer>=NUM_LAYERS is ignored.
- Scroll commit: on i_new_frame, active[l] <= pending[l] for all l. If a write coincides with i_new_frame, the written value is committed in that same cycle. Scroll never changes mid-frame.
- Effective coordinate per layer: ex = x+sx; if ex>=MAP_W then ex-=MAP_W. The same rule applies to ey against MAP_H. One conditional subtract suffices because both operands are < MAP dimension. Coordinates >= MAP are out of contract.
- Tile number n = (ey>>TILE_LOG2)*TILES_PER_LINE + (ex>>TILE_LOG2).
- Pipeline (coordinate presented in cycle T):
  - S0 (T): drive o_tiles_idx_addr[l] = n>>2. Register byte lane n[1:0], pixel offset {ey[TILE_LOG2-1:0], ex[TILE_LOG2-1:0]}, active and layer enables.
  - S1 (T+1): select byte n[1:0] of the tile-index word to get the tile id. Image byte address = {tile_id, offset}. Drive o_tiles_addr[l] = that>>2 and register its byte lane.
  - S2 (T+2): select the colour index per layer. The highest-priority enabled layer whose index != TRANSPARENT_IDX wins. Layer 0 is never transparent. If every layer is disabled or transparent, the index is 0. Drive o_colormap_addr = winner and register active.
  - S3 (T+3): o_pixel_data <= active ? i_colormap_readdata : BLANK_COLOR; o_pixel_valid <= active.
  - Total latency is 4 edges; results are visible in cycle T+4. Throughput is one pixel per cycle with no stalls.
- Byte lane k selects readdata[8k+7:8k], little-endian.
- i_new_frame does not flush the pipeline: pixels already in flight complete with the scroll values they sampled at S0.
- Reset mid-frame clears valid bits immediately, so no stale valid pixel is emitted.

Decomposition:
- Package tile_render_pkg: PIX_X_W=11, PIX_Y_W=10, COLOR_IDX_W=8, PIPE_LATENCY=4, and a byte_lane_select function.
- Sub-module tile_layer_fetch, one generate instance per layer: scroll wrap, tile-number arithmetic, S0/S1 address generation and byte selection. It outputs a per-layer colour index and a valid bit.
- The top level holds the scroll registers, priority compositor, colormap stage and output register.

Test Plan:
- Single layer, no scroll, x=17, y=9, tile-idx word 25 = 32'h0007_0000, tile-image word 114 byte1 = 8'h2A, colormap[0x2A] = 32'h00FF8800. Required: o_tiles_idx_addr=25, o_tiles_addr=114, o_colormap_addr=8'h2A, o_pixel_data=32'h00FF8800 with valid four cycles after presentation.
- Horizontal wrap: scroll_x=797 written then i_new_frame, x=5. Required: ex=2, tile column 0, and image byte offset low 3 bits = 2.
- Shadowing: a write of scroll_x=8 mid-frame leaves the address unchanged until the next i_new_frame. A write coinciding with i_new_frame is used on the first pixel of that frame. A write of scroll_x=800 is dropped.
- Compositing: layer1 index 0x00 gives the layer0 colour. Layer1 index 0x05 gives colormap[5]. Layer1 disabled with index 0x05 gives the layer0 colour.
- Blanking and reset: i_active=0 gives o_pixel_data=BLANK_COLOR and valid=0 with the same 4-cycle latency. Asserting reset with 3 pixels in flight gives valid=0 immediately, and no valid pixels appear until new coordinates are presented.
